// File: rtl/c499_frame_loader.sv
// Byte-serial frame loader for the c499 corrector: collects 6-byte frames into a
// word/check/enable output register and serially loads a lockable key vector.
module c499_frame_loader #(
  parameter int KEY_BITS    = 30,
  parameter int FRAME_BYTES = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                key_si,
  input  logic                key_se,
  output logic                key_locked,
  output logic [KEY_BITS-1:0] key,
  output logic [31:0]         word,
  output logic [7:0]          chk,
  output logic                en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                fmt_err
);

  localparam int CNT_W    = $clog2(KEY_BITS + 1);
  localparam int LAST_IDX = FRAME_BYTES - 1;
  localparam int CHK_IDX  = FRAME_BYTES - 2;

  typedef enum logic [1:0] {
    KEY_EMPTY,
    KEY_SHIFT,
    KEY_LOCKED
  } key_state_e;

  key_state_e          key_state_q;
  logic [CNT_W-1:0]    key_cnt_q;
  logic [KEY_BITS-1:0] key_q;

  logic [2:0]  idx_q, idx_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic [7:0]  chk_buf_q, chk_buf_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  chk_q, chk_d;
  logic        en_q, en_d;
  logic        out_valid_q, out_valid_d;
  logic        fmt_err_q, fmt_err_d;
  logic        last_byte;
  logic        xfer;

  // ---------------- key loader ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state_q <= KEY_EMPTY;
      key_cnt_q   <= '0;
      key_q       <= '0;
    end else begin
      case (key_state_q)
        KEY_EMPTY, KEY_SHIFT: begin
          if (key_se) begin
            key_q     <= {key_q[KEY_BITS-2:0], key_si};
            key_cnt_q <= key_cnt_q + 1'b1;
            if (key_cnt_q == CNT_W'(KEY_BITS - 1)) key_state_q <= KEY_LOCKED;
            else                                    key_state_q <= KEY_SHIFT;
          end
        end
        KEY_LOCKED: key_state_q <= KEY_LOCKED;
        default:    key_state_q <= KEY_EMPTY;
      endcase
    end
  end

  assign key_locked = (key_state_q == KEY_LOCKED);
  assign key        = key_q;

  // ---------------- frame assembly ----------------
  // The control byte may only be taken when the key is usable and the output slot frees up.
  assign last_byte = (idx_q == 3'(LAST_IDX));
  assign in_ready  = !last_byte || (key_locked && (!out_valid_q || out_ready));
  assign xfer      = in_valid && in_ready;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is inferred.
    idx_d       = idx_q;
    word_buf_d  = word_buf_q;
    chk_buf_d   = chk_buf_q;
    word_d      = word_q;
    chk_d       = chk_q;
    en_d        = en_q;
    out_valid_d = out_valid_q;
    fmt_err_d   = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (xfer) begin
      if (last_byte) begin
        idx_d = '0;
        if (in_data[7:1] == 7'd0) begin
          word_d      = word_buf_q;
          chk_d       = chk_buf_q;
          en_d        = in_data[0];
          out_valid_d = 1'b1;
        end else begin
          fmt_err_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(CHK_IDX)) chk_buf_d = in_data;
        else                      word_buf_d[{idx_q[1:0], 3'b000} +: 8] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      word_buf_q  <= '0;
      chk_buf_q   <= '0;
      word_q      <= '0;
      chk_q       <= '0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
      fmt_err_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      word_buf_q  <= word_buf_d;
      chk_buf_q   <= chk_buf_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      fmt_err_q   <= fmt_err_d;
    end
  end

  assign word      = word_q;
  assign chk       = chk_q;
  assign en        = en_q;
  assign out_valid = out_valid_q;
  assign fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_c499_frame_loader.sv
// Directed bench for c499_frame_loader: frame table plus key-load, back-pressure
// and mid-load reset sequences.
module tb_c499_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        key_si;
  logic        key_se;
  logic        key_locked;
  logic [29:0] key;
  logic [31:0] word;
  logic [7:0]  chk;
  logic        en;
  logic        out_valid;
  logic        out_ready;
  logic        fmt_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  c499_frame_loader #(.KEY_BITS(30), .FRAME_BYTES(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_si    (key_si),
    .key_se    (key_se),
    .key_locked(key_locked),
    .key       (key),
    .word      (word),
    .chk       (chk),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fmt_err   (fmt_err)
  );

  typedef struct {
    logic [5:0][7:0] bytes;   // bytes[0] is sent first
    logic [31:0]     exp_word;
    logic [7:0]      exp_chk;
    logic            exp_en;
    logic            exp_valid;
    logic            exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one byte and waits (bounded) until it is transferred.
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL send_byte_timeout: byte %0h not accepted in %0d cycles", b, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [5:0][7:0] bytes);
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
  endtask

  task automatic shift_key(input logic bit_v);
    key_si = bit_v;
    key_se = 1'b1;
    tick();
    key_se = 1'b0;
  endtask

  initial begin
    vecs[0] = '{bytes: {8'h01, 8'hA5, 8'h12, 8'h34, 8'h56, 8'h78},
                exp_word: 32'h12345678, exp_chk: 8'hA5, exp_en: 1'b1, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[1] = '{bytes: {8'h00, 8'h3C, 8'hDE, 8'hAD, 8'hBE, 8'hEF},
                exp_word: 32'hDEADBEEF, exp_chk: 8'h3C, exp_en: 1'b0, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[2] = '{bytes: {8'h03, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11},
                exp_word: 32'hDEADBEEF, exp_chk: 8'h3C, exp_en: 1'b0, exp_valid: 1'b0, exp_err: 1'b1};
    vecs[3] = '{bytes: {8'h01, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00},
                exp_word: 32'h80000000, exp_chk: 8'hFF, exp_en: 1'b1, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[4] = '{bytes: {8'h80, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
                exp_word: 32'h80000000, exp_chk: 8'hFF, exp_en: 1'b1, exp_valid: 1'b0, exp_err: 1'b1};

    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    key_si    = 1'b0;
    key_se    = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_key", 64'(key), 64'h0);
    check("rst_key_locked", 64'(key_locked), 64'h0);
    check("rst_word", 64'(word), 64'h0);
    check("rst_chk_en", 64'({chk, en}), 64'h0);
    check("rst_valid_err", 64'({out_valid, fmt_err}), 64'h0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'h1);

    // Frame with no key: control byte stalls until 30 key bits are in.
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12); send_byte(8'hA5);
    in_data  = 8'h01;
    in_valid = 1'b1;
    repeat (3) tick();
    check("nokey_in_ready", 64'(in_ready), 64'h0);
    check("nokey_out_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 30; i++) begin
      key_si = (i % 2 == 0);
      key_se = 1'b1;
      tick();
      if (i == 28) check("key_not_locked_29", 64'({key_locked, in_ready}), 64'h0);
    end
    key_se = 1'b0;
    check("key_value", 64'(key), 64'h2AAAAAAA);
    check("key_locked", 64'(key_locked), 64'h1);
    check("key_in_ready", 64'(in_ready), 64'h1);
    check("key_out_valid_pre", 64'(out_valid), 64'h0);
    tick();
    in_valid = 1'b0;
    check("first_out_valid", 64'(out_valid), 64'h1);
    check("first_word", 64'(word), 64'h12345678);
    check("first_chk_en", 64'({chk, en}), 64'({8'hA5, 1'b1}));
    shift_key(1'b1);
    check("key_31st_shift", 64'(key), 64'h2AAAAAAA);
    check("key_31st_locked", 64'(key_locked), 64'h1);
    out_ready = 1'b1;
    tick();
    check("first_consumed", 64'(out_valid), 64'h0);

    // Table: frames with the sink always ready.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].bytes);
      check($sformatf("vec%0d_valid", v), 64'(out_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d_err", v), 64'(fmt_err), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_word", v), 64'(word), 64'(vecs[v].exp_word));
      check($sformatf("vec%0d_chk_en", v), 64'({chk, en}), 64'({vecs[v].exp_chk, vecs[v].exp_en}));
      tick();
      check($sformatf("vec%0d_after", v), 64'({out_valid, fmt_err}), 64'h0);
    end

    // Back-pressure: A held, B assembles, B loads on the edge A leaves.
    out_ready = 1'b0;
    send_frame({8'h01, 8'h11, 8'h0B, 8'hAD, 8'hF0, 8'h0D});
    check("bp_a_valid", 64'(out_valid), 64'h1);
    send_byte(8'hEF); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h89); send_byte(8'h22);
    in_data  = 8'h00;
    in_valid = 1'b1;
    repeat (3) tick();
    check("bp_stall_ready", 64'(in_ready), 64'h0);
    check("bp_hold_valid", 64'(out_valid), 64'h1);
    check("bp_hold_word", 64'(word), 64'h0BADF00D);
    check("bp_hold_chk_en", 64'({chk, en}), 64'({8'h11, 1'b1}));
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    check("bp_b_valid", 64'(out_valid), 64'h1);
    check("bp_b_word", 64'(word), 64'h89ABCDEF);
    check("bp_b_chk_en", 64'({chk, en}), 64'({8'h22, 1'b0}));
    tick();
    check("bp_b_consumed", 64'(out_valid), 64'h0);

    // Reset in the middle of a key load and a frame, with simultaneous traffic.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      key_si = 1'b1;
      key_se = 1'b1;
      if (i < 3) begin
        in_data  = 8'hC0 + 8'(i);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    key_se   = 1'b0;
    in_valid = 1'b0;
    check("mid_key_partial", 64'(key), 64'h3FF);
    check("mid_key_unlocked", 64'(key_locked), 64'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_key", 64'({key_locked, key}), 64'h0);
    check("mid_rst_outputs", 64'({word, chk, en, out_valid, fmt_err}), 64'h0);
    #1;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) shift_key(1'b1);
    check("fresh_key", 64'({key_locked, key}), 64'({1'b1, 30'h3FFFFFFF}));
    send_frame({8'h00, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
    check("fresh_valid", 64'(out_valid), 64'h1);
    check("fresh_word", 64'(word), 64'h04030201);
    check("fresh_chk_en", 64'({chk, en}), 64'({8'h05, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
